arp_rx: RTL and testbench



---
 rtl/arp_pkg.sv | 61 ++++++
 rtl/crc32_d8.sv | 17 +
 rtl/arp_rx.sv | 181 ++++++++++++++++++
 tb/tb_arp_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared constants, field offsets, FSM encoding and byte helpers for the ARP receive parser.
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [15:0] ARP_HTYPE    = 16'h0001;
  localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OP_REP   = 16'h0002;
  localparam logic [7:0]  ARP_HLEN     = 8'd6;
  localparam logic [7:0]  ARP_PLEN     = 8'd4;
  localparam logic [7:0]  PRE_BYTE     = 8'h55;
  localparam logic [7:0]  SFD_BYTE     = 8'hD5;

  localparam int unsigned CNT_W = 11;

  // Byte offsets counted from the first byte after the SFD
  localparam logic [CNT_W-1:0] OFF_DST   = 11'd0;
  localparam logic [CNT_W-1:0] OFF_TYPE  = 11'd12;
  localparam logic [CNT_W-1:0] OFF_HTYPE = 11'd14;
  localparam logic [CNT_W-1:0] OFF_PTYPE = 11'd16;
  localparam logic [CNT_W-1:0] OFF_HLEN  = 11'd18;
  localparam logic [CNT_W-1:0] OFF_PLEN  = 11'd19;
  localparam logic [CNT_W-1:0] OFF_OPER  = 11'd20;
  localparam logic [CNT_W-1:0] OFF_SHA   = 11'd22;
  localparam logic [CNT_W-1:0] OFF_SPA   = 11'd28;
  localparam logic [CNT_W-1:0] OFF_THA   = 11'd32;
  localparam logic [CNT_W-1:0] OFF_TPA   = 11'd38;
  localparam logic [CNT_W-1:0] OFF_LAST  = 11'd41;

  // Reflected form of 04C11DB7; residue is stated in normal bit order
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREA = 3'd1,
    BODY = 3'd2,
    TAIL = 3'd3,
    DROP = 3'd4
  } state_e;

  // Byte k of a 48-bit address, k=0 being the first byte on the wire
  function automatic logic [7:0] byte_of48(input logic [47:0] v, input logic [2:0] k);
    logic [47:0] t;
    t = v << {k, 3'b000};
    return t[47:40];
  endfunction

  function automatic logic [7:0] byte_of32(input logic [31:0] v, input logic [1:0] k);
    logic [31:0] t;
    t = v << {k, 3'b000};
    return t[31:24];
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte-per-cycle Ethernet CRC32 update, LSB-first (reflected) register form.
module crc32_d8
  import arp_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      crc_o = (crc_o >> 1) ^ ((crc_o[0] ^ data_i[i]) ? CRC_POLY_REFL : 32'h0);
    end
  end

endmodule

// File: rtl/arp_rx.sv
// GMII receive-side ARP parser: requests for LOCAL_IP raise fs_arp, replies to us pulse arp_reply.
// Optional FCS check enabled by defining ARP_RX_CRC_EN.
module arp_rx
  import arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A80002,
  parameter logic [10:0] MAX_LEN   = 11'd1522
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        e_rxdv,
  input  logic [7:0]  e_rxd,
  input  logic        e_rxer,
  output logic        fs_arp,
  input  logic        fd_arp,
  output logic [47:0] peer_mac,
  output logic [31:0] peer_ip,
  output logic        peer_vld,
  output logic        arp_reply,
  output logic [7:0]  drop_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              dst_loc_q, dst_bc_q, oper_rep_q;
  logic [47:0]       sha_q;
  logic [31:0]       spa_q;
  logic              dst_loc_c, dst_bc_c, byte_ok_c;
  logic              sfd_c, byte_c, commit_c, crc_ok_c;
  logic              req_q, rep_q, fs_arp_q, peer_vld_q, arp_reply_q;
  logic [47:0]       peer_mac_q;
  logic [31:0]       peer_ip_q;
  logic [7:0]        drop_cnt_q;

  // Per-offset field check of the byte currently on e_rxd
  always_comb begin
    dst_loc_c = dst_loc_q & (e_rxd == byte_of48(LOCAL_MAC, cnt_q[2:0]));
    dst_bc_c  = dst_bc_q & (e_rxd == 8'hFF);
    byte_ok_c = 1'b1;
    if (cnt_q == OFF_DST + 11'd5) begin
      byte_ok_c = dst_loc_c | dst_bc_c;
    end else if (cnt_q >= OFF_THA && cnt_q < OFF_TPA) begin
      byte_ok_c = !oper_rep_q || (e_rxd == byte_of48(LOCAL_MAC, 3'(cnt_q - OFF_THA)));
    end else if (cnt_q >= OFF_TPA) begin
      byte_ok_c = (e_rxd == byte_of32(LOCAL_IP, 2'(cnt_q - OFF_TPA)));
    end else begin
      case (cnt_q)
        OFF_TYPE:          byte_ok_c = (e_rxd == ETH_TYPE_ARP[15:8]);
        OFF_TYPE + 11'd1:  byte_ok_c = (e_rxd == ETH_TYPE_ARP[7:0]);
        OFF_HTYPE:         byte_ok_c = (e_rxd == ARP_HTYPE[15:8]);
        OFF_HTYPE + 11'd1: byte_ok_c = (e_rxd == ARP_HTYPE[7:0]);
        OFF_PTYPE:         byte_ok_c = (e_rxd == ETH_TYPE_IP[15:8]);
        OFF_PTYPE + 11'd1: byte_ok_c = (e_rxd == ETH_TYPE_IP[7:0]);
        OFF_HLEN:          byte_ok_c = (e_rxd == ARP_HLEN);
        OFF_PLEN:          byte_ok_c = (e_rxd == ARP_PLEN);
        OFF_OPER:          byte_ok_c = (e_rxd == ARP_OP_REQ[15:8]);
        OFF_OPER + 11'd1:  byte_ok_c = (e_rxd == ARP_OP_REQ[7:0]) || (e_rxd == ARP_OP_REP[7:0]);
        default:           byte_ok_c = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (e_rxdv && e_rxd == PRE_BYTE) state_d = PREA;
      PREA: begin
        if (!e_rxdv)                  state_d = IDLE;
        else if (e_rxer)              state_d = DROP;
        else if (e_rxd == SFD_BYTE)   state_d = BODY;
        else if (e_rxd != PRE_BYTE)   state_d = DROP;
      end
      BODY: begin
        if (!e_rxdv)                  state_d = IDLE;
        else if (e_rxer || !byte_ok_c) state_d = DROP;
        else if (cnt_q == OFF_LAST)   state_d = TAIL;
      end
      TAIL: begin
        if (!e_rxdv)                          state_d = IDLE;
        else if (e_rxer || cnt_q > MAX_LEN)   state_d = DROP;
      end
      DROP: if (!e_rxdv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sfd_c    = (state_q == PREA) && e_rxdv && !e_rxer && (e_rxd == SFD_BYTE);
    byte_c   = ((state_q == BODY) || (state_q == TAIL)) && e_rxdv;
    commit_c = (state_q == TAIL) && !e_rxdv && crc_ok_c;
  end

`ifdef ARP_RX_CRC_EN
  logic [31:0] crc_q, crc_nxt_c;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (e_rxd),
    .crc_o  (crc_nxt_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       crc_q <= 32'hFFFFFFFF;
    else if (sfd_c)  crc_q <= 32'hFFFFFFFF;
    else if (byte_c) crc_q <= crc_nxt_c;
  end

  assign crc_ok_c = (bitrev32(crc_q) == CRC_RESIDUE);
`else
  assign crc_ok_c = 1'b1;
`endif

  // Byte counter, destination match flags and sender shadow registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      dst_loc_q  <= 1'b0;
      dst_bc_q   <= 1'b0;
      oper_rep_q <= 1'b0;
      sha_q      <= '0;
      spa_q      <= '0;
    end else if (sfd_c) begin
      cnt_q      <= '0;
      dst_loc_q  <= 1'b1;
      dst_bc_q   <= 1'b1;
      oper_rep_q <= 1'b0;
    end else if (byte_c) begin
      if (cnt_q != '1) cnt_q <= cnt_q + 11'd1;
      if (cnt_q < OFF_DST + 11'd6) begin
        dst_loc_q <= dst_loc_c;
        dst_bc_q  <= dst_bc_c;
      end
      if (cnt_q == OFF_OPER + 11'd1) oper_rep_q <= (e_rxd == ARP_OP_REP[7:0]);
      if (cnt_q >= OFF_SHA && cnt_q < OFF_SPA) sha_q <= {sha_q[39:0], e_rxd};
      if (cnt_q >= OFF_SPA && cnt_q < OFF_THA) spa_q <= {spa_q[23:0], e_rxd};
    end
  end

  // A new request outranks a same-cycle done; only an unacknowledged overwrite counts as lost
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q       <= 1'b0;
      rep_q       <= 1'b0;
      fs_arp_q    <= 1'b0;
      arp_reply_q <= 1'b0;
      peer_vld_q  <= 1'b0;
      peer_mac_q  <= '0;
      peer_ip_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      req_q       <= commit_c && !oper_rep_q;
      rep_q       <= commit_c && oper_rep_q;
      arp_reply_q <= rep_q;
      if (commit_c) begin
        peer_mac_q <= sha_q;
        peer_ip_q  <= spa_q;
        peer_vld_q <= 1'b1;
      end
      if (req_q) begin
        fs_arp_q <= 1'b1;
        if (fs_arp_q && !fd_arp && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end else if (fd_arp) begin
        fs_arp_q <= 1'b0;
      end
    end
  end

  assign fs_arp    = fs_arp_q;
  assign peer_mac  = peer_mac_q;
  assign peer_ip   = peer_ip_q;
  assign peer_vld  = peer_vld_q;
  assign arp_reply = arp_reply_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: builds ARP frames with FCS and checks commit timing and outputs.
module tb_arp_rx;

  localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SHA1  = 48'h001122334455;
  localparam logic [47:0] SHA2  = 48'hAABBCCDDEEFF;
  localparam logic [31:0] IP1   = 32'hC0A80001;
  localparam logic [31:0] IP9   = 32'hC0A80009;

  logic        clk, rstn, e_rxdv, e_rxer, fd_arp;
  logic [7:0]  e_rxd;
  logic        fs_arp, peer_vld, arp_reply;
  logic [47:0] peer_mac;
  logic [31:0] peer_ip;
  logic [7:0]  drop_cnt;

  int n_checks, n_errors;
  logic [7:0] frm[$];

  arp_rx dut (
    .clk       (clk),
    .rstn      (rstn),
    .e_rxdv    (e_rxdv),
    .e_rxd     (e_rxd),
    .e_rxer    (e_rxer),
    .fs_arp    (fs_arp),
    .fd_arp    (fd_arp),
    .peer_mac  (peer_mac),
    .peer_ip   (peer_ip),
    .peer_vld  (peer_vld),
    .arp_reply (arp_reply),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    e_rxdv = v;
    e_rxd  = d;
    e_rxer = e;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; e_rxdv = 1'b0; e_rxd = 8'h00; e_rxer = 1'b0; fd_arp = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_n(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [47:0] tha,
                       input logic [31:0] tpa, input int npad);
    logic [31:0] c;
    frm.delete();
    push_n(dst, 6);
    push_n(sha, 6);
    push_n(48'(etype), 2);
    push_n(48'h0001, 2);
    push_n(48'h0800, 2);
    push_n(48'h0604, 2);
    push_n(48'(oper), 2);
    push_n(sha, 6);
    push_n(48'(spa), 4);
    push_n(tha, 6);
    push_n(48'(tpa), 4);
    for (int i = 0; i < npad; i++) frm.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    c = ~c;
    push_n(48'(c[7:0]), 1);
    push_n(48'(c[15:8]), 1);
    push_n(48'(c[23:16]), 1);
    push_n(48'(c[31:24]), 1);
  endtask

  // Preamble, SFD, body; optional e_rxer byte or early cut; ends by driving one idle cycle
  task automatic send_frame(input int err_at, input int cut_at);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    foreach (frm[i]) begin
      if (i == cut_at) break;
      drive(1'b1, frm[i], (i == err_at));
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    apply_reset();
    check("rst_fs", fs_arp, 0);
    check("rst_vld", peer_vld, 0);
    check("rst_mac", peer_mac, 0);
    check("rst_ip", peer_ip, 0);
    check("rst_reply", arp_reply, 0);
    check("rst_drop", drop_cnt, 0);

    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, 32'hC0A80003, 18);
    send_frame(-1, -1); tick(3);
    check("tpa_miss_fs", fs_arp, 0);
    check("tpa_miss_vld", peer_vld, 0);

    build(BCAST, 16'h0800, 16'h0001, SHA1, IP1, 48'h0, LIP, 18);
    send_frame(-1, -1); tick(3);
    check("type_ip_fs", fs_arp, 0);
    check("type_ip_vld", peer_vld, 0);

    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, LIP, 18);
    send_frame(25, -1); tick(3);
    check("rxer_fs", fs_arp, 0);
    check("rxer_vld", peer_vld, 0);
    send_frame(-1, 30); tick(3);
    check("runt_fs", fs_arp, 0);
    check("runt_vld", peer_vld, 0);

    send_frame(-1, -1);
    tick(1);
    check("req_fs_lat1", fs_arp, 0);
    check("req_vld", peer_vld, 1);
    tick(1);
    check("req_fs_lat2", fs_arp, 1);
    check("req_mac", peer_mac, 48'h001122334455);
    check("req_ip", peer_ip, 32'hC0A80001);
    fd_arp = 1'b1; tick(1); fd_arp = 1'b0;
    check("fd_clear", fs_arp, 0);

    build(LMAC, 16'h0806, 16'h0002, SHA2, IP1, LMAC, LIP, 18);
    send_frame(-1, -1);
    tick(1); check("rep_pulse0", arp_reply, 0);
    tick(1); check("rep_pulse1", arp_reply, 1);
    tick(1); check("rep_pulse2", arp_reply, 0);
    check("rep_fs", fs_arp, 0);
    check("rep_mac", peer_mac, 48'hAABBCCDDEEFF);
    check("rep_ip", peer_ip, 32'hC0A80001);

    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, LIP, 18);
    send_frame(-1, -1);
    build(LMAC, 16'h0806, 16'h0001, SHA2, IP9, 48'h0, LIP, 18);
    send_frame(-1, -1); tick(2);
    check("b2b_fs", fs_arp, 1);
    check("b2b_drop", drop_cnt, 1);
    check("b2b_ip", peer_ip, 32'hC0A80009);

    apply_reset();
    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, LIP, 18);
    send_frame(-1, -1); tick(2);
    check("col_a_fs", fs_arp, 1);
    send_frame(-1, -1); tick(1);
    fd_arp = 1'b1; tick(1); fd_arp = 1'b0;
    check("col_b_fs", fs_arp, 1);
    check("col_b_drop", drop_cnt, 0);
    fd_arp = 1'b1; tick(1); fd_arp = 1'b0;
    check("col_fd_clear", fs_arp, 0);

    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, frm[i], 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_vld", peer_vld, 0);
    check("mid_rst_mac", peer_mac, 0);
    check("mid_rst_ip", peer_ip, 0);
    check("mid_rst_fs", fs_arp, 0);
    e_rxdv = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    send_frame(-1, -1); tick(2);
    check("post_rst_fs", fs_arp, 1);
    check("post_rst_mac", peer_mac, 48'h001122334455);

`ifdef ARP_RX_CRC_EN
    apply_reset();
    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, LIP, 18);
    frm[frm.size() - 2] = frm[frm.size() - 2] ^ 8'h10;
    send_frame(-1, -1); tick(3);
    check("crc_bad_vld", peer_vld, 0);
    check("crc_bad_fs", fs_arp, 0);
`endif

    apply_reset();
    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, LIP, 1478);
    send_frame(-1, -1); tick(3);
    check("maxlen_over_vld", peer_vld, 0);
    build(BCAST, 16'h0806, 16'h0001, SHA1, IP1, 48'h0, LIP, 1477);
    send_frame(-1, -1); tick(2);
    check("maxlen_edge_fs", fs_arp, 1);
    check("maxlen_edge_vld", peer_vld, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
